// File: rtl/reg_bank_encap_pkg.sv
// Shared widths, register indices and control-store encodings for the
// ARMv4 register bank.
package reg_bank_encap_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;

    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] R15 = 4'd15;

    typedef enum logic [1:0] {
        RM_IR_3_0   = 2'b00,
        RM_IR_11_8  = 2'b01,
        RM_COUNTER  = 2'b10,
        RM_IR_15_12 = 2'b11
    } rm_sel_e;

    typedef enum logic [1:0] {
        RD_FIELD    = 2'b00,
        RD_LINK     = 2'b01,
        RD_COUNTER  = 2'b10,
        RD_RN_FIELD = 2'b11
    } rd_sel_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'b00,
        PC_INC   = 2'b01,
        PC_ALU   = 2'b10,
        PC_HOLD2 = 2'b11
    } pc_sel_e;

    typedef enum logic {
        DATA_ALU = 1'b0,
        DATA_B   = 1'b1
    } data_sel_e;

    // R15 was advanced at fetch, so +4 here gives the architectural PC+8.
    function automatic logic [DATA_W-1:0] read_adjust(input logic [3:0] idx,
                                                      input logic [DATA_W-1:0] val);
        return (idx == R15) ? val + DATA_W'(4) : val;
    endfunction

endpackage

// File: rtl/reg_bank_encap_if.sv
// Control-store and datapath signals of the register bank (B_BUS excluded:
// it is a resolved tri-state net and stays a plain inout port).
interface reg_bank_encap_if;
    import reg_bank_encap_pkg::*;

    logic              LATCH_REG;
    logic              IR_RD_MUX;
    logic              IR_RN_MUX;
    rm_sel_e           IR_RM_MUX;
    rd_sel_e           RD_MUX;
    pc_sel_e           PC_MUX;
    data_sel_e         DATA_MUX;
    logic              REG_GATE_B;
    logic              REG_GATE_C;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] ALU_BUS;
    logic [3:0]        REG_COUNTER;
    logic [DATA_W-1:0] A_BUS;
    logic [DATA_W-1:0] C_BUS;
    logic [DATA_W-1:0] ST;
    logic [DATA_W-1:0] PC;

    modport master (
        output LATCH_REG, IR_RD_MUX, IR_RN_MUX, IR_RM_MUX, RD_MUX, PC_MUX,
               DATA_MUX, REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
        input  A_BUS, C_BUS, ST, PC
    );

    modport slave (
        input  LATCH_REG, IR_RD_MUX, IR_RN_MUX, IR_RM_MUX, RD_MUX, PC_MUX,
               DATA_MUX, REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
        output A_BUS, C_BUS, ST, PC
    );

endinterface

// File: rtl/reg_bank_encap_reg_file.sv
// 16x32 register file: four raw read ports, one write port and a dedicated
// R15 next-value input that overrides a same-cycle write to R15.
module reg_file_16x32
    import reg_bank_encap_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int DEPTH = NREG,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a_addr,
    input  logic [AW-1:0]    b_addr,
    input  logic [AW-1:0]    c_addr,
    input  logic [AW-1:0]    st_addr,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] c_data,
    output logic [WIDTH-1:0] st_data,
    output logic [WIDTH-1:0] pc_data,
    input  logic             we,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             pc_we,
    input  logic [WIDTH-1:0] pc_next
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we && !(pc_we && (w_addr == AW'(DEPTH - 1)))) begin
                regs[w_addr] <= w_data;
            end
            if (pc_we) begin
                regs[DEPTH-1] <= pc_next;
            end
        end
    end

    assign a_data  = regs[a_addr];
    assign b_data  = regs[b_addr];
    assign c_data  = regs[c_addr];
    assign st_data = regs[st_addr];
    assign pc_data = regs[DEPTH-1];

endmodule

// File: rtl/reg_bank_encap.sv
// ARMv4 register bank with IR field selects, R15 read adjust and the
// tri-state B bus driver.
module reg_bank_encap
    import reg_bank_encap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    reg_bank_encap_if.slave      bus,
    inout  wire  [DATA_W-1:0]    B_BUS
);

    logic [3:0]        rn_idx, rd_field, rm_idx, dest_idx, rs_idx, st_idx;
    logic [DATA_W-1:0] a_raw, b_raw, c_raw, st_raw, pc_raw;
    logic [DATA_W-1:0] b_val, w_data, pc_next;
    logic              pc_we;
    logic              unused_ir;

    assign rn_idx   = bus.IR_RN_MUX ? bus.IR[15:12] : bus.IR[19:16];
    assign rd_field = bus.IR_RD_MUX ? bus.IR[19:16] : bus.IR[15:12];
    assign rs_idx   = bus.IR[11:8];
    assign st_idx   = bus.IR[15:12];
    assign unused_ir = &{1'b0, bus.IR[31:20], bus.IR[7:4]};

    always_comb begin
        rm_idx = bus.IR[3:0];
        unique case (bus.IR_RM_MUX)
            RM_IR_3_0:   rm_idx = bus.IR[3:0];
            RM_IR_11_8:  rm_idx = bus.IR[11:8];
            RM_COUNTER:  rm_idx = bus.REG_COUNTER;
            RM_IR_15_12: rm_idx = bus.IR[15:12];
            default:     rm_idx = bus.IR[3:0];
        endcase
    end

    always_comb begin
        dest_idx = rd_field;
        unique case (bus.RD_MUX)
            RD_FIELD:    dest_idx = rd_field;
            RD_LINK:     dest_idx = R14;
            RD_COUNTER:  dest_idx = bus.REG_COUNTER;
            RD_RN_FIELD: dest_idx = rn_idx;
            default:     dest_idx = rd_field;
        endcase
    end

    // B_BUS is sampled as resolved, so a register move through our own drive is legal.
    assign w_data  = (bus.DATA_MUX == DATA_B) ? B_BUS : bus.ALU_BUS;
    assign pc_we   = (bus.PC_MUX == PC_INC) || (bus.PC_MUX == PC_ALU);
    assign pc_next = (bus.PC_MUX == PC_INC) ? pc_raw + DATA_W'(4) : bus.ALU_BUS;

    reg_file_16x32 #(.WIDTH(DATA_W), .DEPTH(NREG)) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (rn_idx),
        .b_addr  (rm_idx),
        .c_addr  (rs_idx),
        .st_addr (st_idx),
        .a_data  (a_raw),
        .b_data  (b_raw),
        .c_data  (c_raw),
        .st_data (st_raw),
        .pc_data (pc_raw),
        .we      (bus.LATCH_REG),
        .w_addr  (dest_idx),
        .w_data  (w_data),
        .pc_we   (pc_we),
        .pc_next (pc_next)
    );

    assign b_val     = read_adjust(rm_idx, b_raw);
    assign B_BUS     = bus.REG_GATE_B ? b_val : {DATA_W{1'bz}};
    assign bus.A_BUS = read_adjust(rn_idx, a_raw);
    assign bus.C_BUS = bus.REG_GATE_C ? read_adjust(rs_idx, c_raw) : '0;
    assign bus.ST    = read_adjust(st_idx, st_raw);
    assign bus.PC    = pc_raw;

endmodule

// File: tb/tb_reg_bank_encap.sv
// Vector table plus scoreboard bench for reg_bank_encap, with a hand-written
// mid-cycle reset sequence.
module tb_reg_bank_encap;
    import reg_bank_encap_pkg::*;

    localparam bit [4:0] M_PC = 5'b10000;
    localparam bit [4:0] M_A  = 5'b01000;
    localparam bit [4:0] M_B  = 5'b00100;
    localparam bit [4:0] M_C  = 5'b00010;
    localparam bit [4:0] M_ST = 5'b00001;

    typedef struct {
        string       name;
        bit          clk_edge;
        logic        latch;
        logic        rd_ir;
        logic        rn_ir;
        rm_sel_e     rm;
        rd_sel_e     rd;
        pc_sel_e     pcm;
        data_sel_e   dm;
        logic        gate_b;
        logic        gate_c;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [3:0]  cnt;
        logic        ext_en;
        logic [31:0] ext_val;
        bit   [4:0]  mask;
        logic [31:0] exp_pc, exp_a, exp_b, exp_c, exp_st;
    } vec_t;

    typedef struct {
        string       name;
        bit   [4:0]  mask;
        logic [31:0] pc, a, b, c, st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ext_en;
    logic [31:0] ext_val;
    wire  [31:0] b_bus;

    reg_bank_encap_if bus();

    assign b_bus = ext_en ? ext_val : 32'hzzzz_zzzz;

    reg_bank_encap dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .B_BUS (b_bus)
    );

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(string name, bit clk_edge, logic [31:0] ir,
                                logic [31:0] alu, bit [4:0] mask,
                                logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                                logic [31:0] c, logic [31:0] st);
        vec_t v;
        v.name = name;   v.clk_edge = clk_edge;
        v.latch = 1'b0;  v.rd_ir = 1'b0;  v.rn_ir = 1'b0;
        v.rm = RM_IR_3_0; v.rd = RD_FIELD; v.pcm = PC_HOLD; v.dm = DATA_ALU;
        v.gate_b = 1'b0; v.gate_c = 1'b0;
        v.ir = ir;       v.alu = alu;     v.cnt = 4'd0;
        v.ext_en = 1'b0; v.ext_val = 32'h0;
        v.mask = mask;
        v.exp_pc = pc; v.exp_a = a; v.exp_b = b; v.exp_c = c; v.exp_st = st;
        return v;
    endfunction

    task automatic pushExpected(string name, bit [4:0] mask, logic [31:0] pc,
                                logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [31:0] st);
        exp_t e;
        e.name = name; e.mask = mask;
        e.pc = pc; e.a = a; e.b = b; e.c = c; e.st = st;
        sb.push_back(e);
    endtask

    task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s %s: got %08h, expected %08h", name, field, act, want);
        end
    endtask

    task automatic goIdle();
        bus.LATCH_REG = 1'b0;
        bus.PC_MUX    = PC_HOLD;
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        bus.LATCH_REG   = v.latch;
        bus.IR_RD_MUX   = v.rd_ir;
        bus.IR_RN_MUX   = v.rn_ir;
        bus.IR_RM_MUX   = v.rm;
        bus.RD_MUX      = v.rd;
        bus.PC_MUX      = v.pcm;
        bus.DATA_MUX    = v.dm;
        bus.REG_GATE_B  = v.gate_b;
        bus.REG_GATE_C  = v.gate_c;
        bus.IR          = v.ir;
        bus.ALU_BUS     = v.alu;
        bus.REG_COUNTER = v.cnt;
        ext_en          = v.ext_en;
        ext_val         = v.ext_val;
        pushExpected(v.name, v.mask, v.exp_pc, v.exp_a, v.exp_b, v.exp_c, v.exp_st);
        if (v.clk_edge) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        if (e.mask[4]) cmp(e.name, "PC",    bus.PC,    e.pc);
        if (e.mask[3]) cmp(e.name, "A_BUS", bus.A_BUS, e.a);
        if (e.mask[2]) cmp(e.name, "B_BUS", b_bus,     e.b);
        if (e.mask[1]) cmp(e.name, "C_BUS", bus.C_BUS, e.c);
        if (e.mask[0]) cmp(e.name, "ST",    bus.ST,    e.st);
    endtask

    initial begin
        vec_t v;

        // Register contents evolve vector by vector; expected values follow that history.
        v = mk("reset_state", 0, 32'h0, 32'h0, M_PC|M_A|M_B|M_C|M_ST, 0, 0, 32'h12345678, 0, 0);
        v.ext_en = 1; v.ext_val = 32'h12345678; vecs.push_back(v);
        v = mk("reset_r15_read", 0, 32'h000F0000, 0, M_A, 0, 4, 0, 0, 0); vecs.push_back(v);
        v = mk("no_bypass", 0, 32'hE0812003, 32'hDEADBEEF, M_ST, 0, 0, 0, 0, 0);
        v.latch = 1; vecs.push_back(v);
        v = mk("alu_wr_r2", 1, 32'hE0812003, 32'hDEADBEEF, M_PC|M_A|M_ST, 0, 0, 0, 0, 32'hDEADBEEF);
        v.latch = 1; vecs.push_back(v);
        v = mk("read_r2_rn", 0, 32'h00020000, 0, M_A, 0, 32'hDEADBEEF, 0, 0, 0); vecs.push_back(v);
        v = mk("wr_r3", 1, 32'h00003000, 32'h11, M_ST, 0, 0, 0, 0, 32'h11); v.latch = 1; vecs.push_back(v);
        v = mk("wr_r4", 1, 32'h00004000, 32'h22, M_ST, 0, 0, 0, 0, 32'h22); v.latch = 1; vecs.push_back(v);
        v = mk("b_rm_ir30", 0, 32'h00000403, 0, M_B|M_C, 0, 0, 32'h11, 0, 0);
        v.gate_b = 1; vecs.push_back(v);
        v = mk("b_rm_ir118", 0, 32'h00000403, 0, M_B|M_C, 0, 0, 32'h22, 32'h22, 0);
        v.gate_b = 1; v.rm = RM_IR_11_8; v.gate_c = 1; vecs.push_back(v);
        v = mk("b_rm_cnt", 0, 32'h00000403, 0, M_B, 0, 0, 32'hDEADBEEF, 0, 0);
        v.gate_b = 1; v.rm = RM_COUNTER; v.cnt = 4'd2; vecs.push_back(v);
        v = mk("b_rm_r15", 0, 32'h0000F000, 0, M_B|M_ST, 0, 0, 4, 0, 4);
        v.gate_b = 1; v.rm = RM_IR_15_12; vecs.push_back(v);
        v = mk("rn_mux_ir1", 0, 32'h00003000, 0, M_A, 0, 32'h11, 0, 0, 0); v.rn_ir = 1; vecs.push_back(v);
        v = mk("pc_inc1", 1, 32'h000F0000, 0, M_PC|M_A, 4, 8, 0, 0, 0);   v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_inc2", 1, 32'h000F0000, 0, M_PC|M_A, 8, 12, 0, 0, 0);  v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_inc3", 1, 32'h000F0000, 0, M_PC|M_A, 12, 16, 0, 0, 0); v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_branch", 1, 32'h000F0000, 32'h100, M_PC, 32'h100, 0, 0, 0, 0); v.pcm = PC_ALU; vecs.push_back(v);
        v = mk("pc_set_top", 1, 32'h000F0000, 32'hFFFFFFFC, M_PC|M_A, 32'hFFFFFFFC, 0, 0, 0, 0);
        v.pcm = PC_ALU; vecs.push_back(v);
        v = mk("pc_wrap", 1, 32'h000F0000, 0, M_PC|M_A, 0, 4, 0, 0, 0); v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_to4", 1, 32'h0, 0, M_PC, 4, 0, 0, 0, 0); v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_to8", 1, 32'h0, 0, M_PC, 8, 0, 0, 0, 0); v.pcm = PC_INC; vecs.push_back(v);
        v = mk("collision", 1, 32'h0000F000, 32'h50, M_PC|M_ST, 12, 0, 0, 0, 16);
        v.latch = 1; v.pcm = PC_INC; vecs.push_back(v);
        v = mk("pc_hold_11", 1, 32'h0, 32'h999, M_PC, 12, 0, 0, 0, 0); v.pcm = PC_HOLD2; vecs.push_back(v);
        v = mk("latch_r15", 1, 32'h0000F000, 32'h41, M_PC|M_ST, 32'h41, 0, 0, 0, 32'h45);
        v.latch = 1; vecs.push_back(v);
        v = mk("link_r14", 1, 32'h000E0000, 32'h2C, M_A|M_ST, 0, 32'h2C, 0, 0, 0);
        v.latch = 1; v.rd = RD_LINK; vecs.push_back(v);
        v = mk("rd_mux_ir1", 1, 32'h00050000, 32'h77, M_A|M_ST, 0, 32'h77, 0, 0, 0);
        v.latch = 1; v.rd_ir = 1; vecs.push_back(v);
        v = mk("rd_rn_field", 1, 32'h00006000, 32'h66, M_A|M_ST, 0, 32'h66, 0, 0, 32'h66);
        v.latch = 1; v.rd = RD_RN_FIELD; v.rn_ir = 1; vecs.push_back(v);
        v = mk("cnt_ext_b", 1, 32'h00007000, 32'h0, M_B|M_ST, 0, 0, 32'h5A5A, 0, 32'h5A5A);
        v.latch = 1; v.rd = RD_COUNTER; v.cnt = 4'd7; v.dm = DATA_B;
        v.ext_en = 1; v.ext_val = 32'h5A5A; vecs.push_back(v);
        v = mk("self_move", 1, 32'h00008003, 32'h0, M_B|M_ST, 0, 0, 32'h11, 0, 32'h11);
        v.latch = 1; v.gate_b = 1; v.dm = DATA_B; vecs.push_back(v);
        v = mk("move_r15", 1, 32'h0000900F, 32'h0, M_PC|M_B|M_ST, 32'h41, 0, 32'h45, 0, 32'h45);
        v.latch = 1; v.gate_b = 1; v.dm = DATA_B; vecs.push_back(v);
        v = mk("c_r15", 0, 32'h00000F00, 0, M_C|M_ST, 0, 0, 0, 32'h45, 0); v.gate_c = 1; vecs.push_back(v);

        rst = 1'b1;
        ext_en = 1'b0;
        ext_val = 32'h0;
        bus.IR_RD_MUX = 0; bus.IR_RN_MUX = 0; bus.IR_RM_MUX = RM_IR_3_0;
        bus.RD_MUX = RD_FIELD; bus.DATA_MUX = DATA_ALU;
        bus.REG_GATE_B = 0; bus.REG_GATE_C = 0;
        bus.IR = 0; bus.ALU_BUS = 0; bus.REG_COUNTER = 0;
        goIdle();
        #12 rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
            goIdle();
        end

        // Mid-cycle reset: PC clears without a clock edge, and a write pending on the edge is lost.
        @(negedge clk);
        bus.REG_GATE_B = 0; bus.REG_GATE_C = 0; bus.DATA_MUX = DATA_ALU; ext_en = 0;
        bus.RD_MUX = RD_FIELD; bus.IR_RD_MUX = 1; bus.IR_RN_MUX = 0;
        bus.IR = 32'h000A8000; bus.ALU_BUS = 32'hAA; bus.LATCH_REG = 1;
        #1;
        pushExpected("pre_reset", M_PC|M_ST, 32'h41, 0, 0, 0, 32'h11);
        checkOutput();
        rst = 1'b1;
        #1;
        pushExpected("async_reset", M_PC|M_A|M_ST, 0, 0, 0, 0, 0);
        checkOutput();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        bus.LATCH_REG = 0;
        bus.IR = 32'h0000A000;
        #1;
        pushExpected("write_lost", M_PC|M_ST, 0, 0, 0, 0, 0);
        checkOutput();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
